// File: rtl/frame_buffer_dbl.sv
// Double-buffered pixel store: Wishbone writes the back page, led_matrix reads the front page.
// Optional FRAME_BUFFER_COPY_EN: on a swap the new back page is loaded from the new front page.
module frame_buffer_dbl #(
  parameter int N_COLS        = 4,
  parameter int N_ROWS        = 4,
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 8,
  parameter int BASE_ADDRESS  = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [ADDRESS_WIDTH-1:0] adr_i,
  input  logic [DATA_WIDTH-1:0]    dat_i,
  output logic [DATA_WIDTH-1:0]    dat_o,
  input  logic                     we_i,
  input  logic                     sel_i,
  input  logic                     stb_i,
  input  logic                     cyc_i,
  input  logic [2:0]               cti_i,
  output logic                     ack_o,
  input  logic [ADDRESS_WIDTH-1:0] frame_adr_i,
  input  logic                     frame_cyc_i,
  output logic [DATA_WIDTH-1:0]    frame_dat_o,
  output logic                     frame_ack_o
);

  localparam int NPIX  = N_COLS * N_ROWS;
  localparam int IDX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [ADDRESS_WIDTH-1:0] NPIX_A   = ADDRESS_WIDTH'(NPIX);
  localparam logic [ADDRESS_WIDTH-1:0] CTRL_OFF = ADDRESS_WIDTH'(32'h100);
  localparam logic [ADDRESS_WIDTH-1:0] BASE_A   = ADDRESS_WIDTH'(BASE_ADDRESS);

  logic [DATA_WIDTH-1:0] mem     [2][NPIX];
  logic [DATA_WIDTH-1:0] mem_nxt [2][NPIX];

  logic                     front, back, front_nxt;
  logic                     swap_pending, swap_pending_nxt;
  logic [ADDRESS_WIDTH-1:0] off;
  logic                     wb_acc, pix_sel, ctrl_sel, pix_wr, ctrl_wr;
  logic                     frame_acc, swap;
  logic [IDX_W-1:0]         wb_idx, fr_idx;
  logic [DATA_WIDTH-1:0]    wb_rd, fr_rd;
  logic                     unused_ok;

  assign unused_ok = ^cti_i;

  assign off      = adr_i - BASE_A;
  assign pix_sel  = (off < NPIX_A);
  assign ctrl_sel = (off == CTRL_OFF);
  assign wb_idx   = off[IDX_W-1:0];
  assign fr_idx   = frame_adr_i[IDX_W-1:0];

  assign wb_acc    = stb_i & cyc_i & ~ack_o;
  assign pix_wr    = wb_acc & we_i & sel_i & pix_sel;
  assign ctrl_wr   = wb_acc & we_i & sel_i & ctrl_sel;
  assign frame_acc = frame_cyc_i & ~frame_ack_o;

  // The swap is taken on the accepted fetch of pixel 0 so a whole frame comes from one page
  assign swap      = frame_acc & (frame_adr_i == '0) & swap_pending;
  assign back      = ~front;
  assign front_nxt = front ^ swap;

  always_comb begin
    swap_pending_nxt = swap_pending & ~swap;
    if (ctrl_wr) swap_pending_nxt = dat_i[0];
  end

  // Pixel write targets the page that was back at cycle start, before any copy
  always_comb begin
    mem_nxt = mem;
    if (pix_wr) mem_nxt[back][wb_idx] = dat_i;
`ifdef FRAME_BUFFER_COPY_EN
    if (swap) begin
      for (int i = 0; i < NPIX; i++) mem_nxt[front][i] = mem_nxt[back][i];
    end
`endif
  end

  always_comb begin
    wb_rd = '0;
    if (ctrl_sel)     wb_rd = {{(DATA_WIDTH-2){1'b0}}, front, swap_pending};
    else if (pix_sel) wb_rd = mem[back][wb_idx];
  end

  assign fr_rd = (frame_adr_i < NPIX_A) ? mem[front_nxt][fr_idx] : '0;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int p = 0; p < 2; p++) begin
        for (int i = 0; i < NPIX; i++) mem[p][i] <= '0;
      end
      front        <= 1'b0;
      swap_pending <= 1'b0;
      ack_o        <= 1'b0;
      dat_o        <= '0;
      frame_ack_o  <= 1'b0;
      frame_dat_o  <= '0;
    end else begin
      mem          <= mem_nxt;
      front        <= front_nxt;
      swap_pending <= swap_pending_nxt;
      ack_o        <= wb_acc;
      frame_ack_o  <= frame_acc;
      if (wb_acc)    dat_o       <= wb_rd;
      if (frame_acc) frame_dat_o <= fr_rd;
    end
  end

endmodule

// File: tb/tb_frame_buffer_dbl.sv
// Randomized self-checking bench for frame_buffer_dbl against a page-level reference model.
// Honors FRAME_BUFFER_COPY_EN the same way the design does.
module tb_frame_buffer_dbl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [15:0] adr_i = '0;
  logic [7:0]  dat_i = '0;
  logic [7:0]  dat_o;
  logic        we_i = 1'b0, sel_i = 1'b0, stb_i = 1'b0, cyc_i = 1'b0;
  logic [2:0]  cti_i = '0;
  logic        ack_o;
  logic [15:0] frame_adr_i = '0;
  logic        frame_cyc_i = 1'b0;
  logic [7:0]  frame_dat_o;
  logic        frame_ack_o;

  frame_buffer_dbl dut (
    .clk_i(clk_i), .rst_i(rst_i), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o),
    .we_i(we_i), .sel_i(sel_i), .stb_i(stb_i), .cyc_i(cyc_i), .cti_i(cti_i),
    .ack_o(ack_o), .frame_adr_i(frame_adr_i), .frame_cyc_i(frame_cyc_i),
    .frame_dat_o(frame_dat_o), .frame_ack_o(frame_ack_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // Reference model: two pages, a front selector and the pending flag
  logic [7:0] pg [2][16];
  logic       m_front, m_pend;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 16; i++) pg[p][i] = 8'h00;
    m_front = 1'b0;
    m_pend  = 1'b0;
  endtask

  function automatic logic [7:0] m_wb_read(input logic [15:0] a);
    if (a < 16)       return pg[!m_front][a[3:0]];
    if (a == 16'h100) return {6'b0, m_front, m_pend};
    return 8'h00;
  endfunction

  task automatic m_wb_write(input logic [15:0] a, input logic [7:0] d);
    if (a < 16)            pg[!m_front][a[3:0]] = d;
    else if (a == 16'h100) m_pend = d[0];
  endtask

  task automatic m_frame(input logic [15:0] idx, output logic [7:0] exp);
    if (m_pend && idx == 0) begin
      m_front = !m_front;
      m_pend  = 1'b0;
`ifdef FRAME_BUFFER_COPY_EN
      for (int i = 0; i < 16; i++) pg[!m_front][i] = pg[m_front][i];
`endif
    end
    exp = (idx < 16) ? pg[m_front][idx[3:0]] : 8'h00;
  endtask

  task automatic wb_cycle(input logic [15:0] a, input logic w, input logic [7:0] d,
                          output logic [7:0] rd);
    logic pre, post;
    @(negedge clk_i);
    adr_i = a; we_i = w; dat_i = d; sel_i = 1'b1; stb_i = 1'b1; cyc_i = 1'b1;
    pre = ack_o;
    @(posedge clk_i); #1;
    post = ack_o;
    rd = dat_o;
    stb_i = 1'b0; cyc_i = 1'b0; we_i = 1'b0;
    chk("wb_ack_latency", {30'd0, pre, post}, 32'd1);
    @(posedge clk_i); #1;
  endtask

  task automatic wb_wr(input logic [15:0] a, input logic [7:0] d);
    logic [7:0] rd;
    wb_cycle(a, 1'b1, d, rd);
    m_wb_write(a, d);
  endtask

  task automatic wb_rd(input logic [15:0] a, input string tag, output logic [7:0] got);
    logic [7:0] exp;
    exp = m_wb_read(a);
    wb_cycle(a, 1'b0, 8'h00, got);
    chk(tag, got, exp);
  endtask

  task automatic frame_rd(input logic [15:0] idx, input string tag, output logic [7:0] got);
    logic pre, post;
    logic [7:0] exp;
    @(negedge clk_i);
    frame_cyc_i = 1'b1; frame_adr_i = idx;
    pre = frame_ack_o;
    @(posedge clk_i); #1;
    post = frame_ack_o;
    got = frame_dat_o;
    frame_cyc_i = 1'b0;
    m_frame(idx, exp);
    chk("frame_ack_latency", {30'd0, pre, post}, 32'd1);
    chk(tag, got, exp);
    @(posedge clk_i); #1;
  endtask

  // Pixel write and frame fetch in the same cycle (write index differs from fetch index)
  task automatic dual(input logic [15:0] wa, input logic [7:0] d, input logic [15:0] fidx);
    logic [7:0] exp;
    @(negedge clk_i);
    adr_i = wa; we_i = 1'b1; dat_i = d; sel_i = 1'b1; stb_i = 1'b1; cyc_i = 1'b1;
    frame_cyc_i = 1'b1; frame_adr_i = fidx;
    @(posedge clk_i); #1;
    stb_i = 1'b0; cyc_i = 1'b0; we_i = 1'b0; frame_cyc_i = 1'b0;
    m_wb_write(wa, d);
    m_frame(fidx, exp);
    chk("dual_acks", {30'd0, ack_o, frame_ack_o}, 32'd3);
    chk("dual_frame_data", frame_dat_o, exp);
    @(posedge clk_i); #1;
  endtask

  initial begin
    logic [7:0] g;
    logic [15:0] a;
    int acks;
    int op;

    m_reset();
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_outputs", {14'd0, ack_o, frame_ack_o, dat_o, frame_dat_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    chk("idle_acks_low", {30'd0, ack_o, frame_ack_o}, 32'd0);

    for (int i = 0; i < 16; i++) begin
      frame_rd(16'(i), "reset_frame", g);
      chk("reset_frame_zero", g, 8'h00);
    end
    wb_rd(16'h100, "reset_status", g);
    chk("reset_status_zero", g, 8'h00);

    wb_wr(16'h0040, 8'h77);
    wb_rd(16'h0040, "other_offset", g);
    chk("other_offset_zero", g, 8'h00);

    wb_wr(16'h0005, 8'h3C);
    frame_rd(16'd5, "back_hidden", g);
    chk("back_hidden_zero", g, 8'h00);
    wb_rd(16'h0005, "back_read", g);
    chk("back_read_3c", g, 8'h3C);

    wb_wr(16'h100, 8'h01);
    wb_wr(16'h100, 8'h00);
    frame_rd(16'd0, "cancel_fetch0", g);
    wb_rd(16'h100, "cancel_status", g);
    chk("cancel_status_zero", g, 8'h00);

    wb_wr(16'h100, 8'h01);
    wb_rd(16'h100, "pend_status", g);
    chk("pend_status_01", g, 8'h01);
    frame_rd(16'd3, "noswap_fetch3", g);
    wb_rd(16'h100, "still_pend", g);
    chk("still_pend_01", g, 8'h01);
    frame_rd(16'd0, "swap_fetch0", g);
    wb_rd(16'h100, "swapped_status", g);
    chk("swapped_status_02", g, 8'h02);
    frame_rd(16'd5, "new_front5", g);
    chk("new_front5_3c", g, 8'h3C);
    wb_rd(16'h0005, "post_swap_back5", g);
`ifdef FRAME_BUFFER_COPY_EN
    chk("post_swap_back5_copy", g, 8'h3C);
`else
    chk("post_swap_back5_stale", g, 8'h00);
`endif

    // Held strobe: ack every second cycle
    @(negedge clk_i);
    adr_i = 16'h100; we_i = 1'b0; sel_i = 1'b1; stb_i = 1'b1; cyc_i = 1'b1;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_i); #1;
      if (ack_o) acks++;
    end
    stb_i = 1'b0; cyc_i = 1'b0;
    chk("held_strobe_acks", acks, 2);
    @(posedge clk_i); #1;

    // Randomized mix
    for (int n = 0; n < 400; n++) begin
      op = $urandom_range(0, 9);
      case (op)
        0, 1: wb_wr(16'($urandom_range(0, 15)), 8'($urandom));
        2:    wb_rd(16'($urandom_range(0, 15)), "rnd_pix_read", g);
        3:    wb_wr(16'h100, {7'd0, ($urandom_range(0, 3) != 0)});
        4:    wb_rd(16'h100, "rnd_status", g);
        5:    frame_rd(16'd0, "rnd_fetch0", g);
        6:    frame_rd(16'($urandom_range(0, 19)), "rnd_fetch", g);
        7: begin
          case ($urandom_range(0, 3))
            0: a = 16'h0010;
            1: a = 16'h0040;
            2: a = 16'h0101;
            default: a = 16'hFFFF;
          endcase
          if ($urandom_range(0, 1) == 1) wb_wr(a, 8'($urandom));
          else wb_rd(a, "rnd_other_read", g);
        end
        default: dual(16'($urandom_range(1, 15)), 8'($urandom), 16'd0);
      endcase
    end

    // Reset in the middle of a Wishbone cycle with a swap pending
    wb_wr(16'h100, 8'h01);
    wb_wr(16'h0005, 8'h5A);
    @(negedge clk_i);
    adr_i = 16'h0005; we_i = 1'b0; sel_i = 1'b1; stb_i = 1'b1; cyc_i = 1'b1;
    @(posedge clk_i); #1;
    chk("pre_reset_ack", ack_o, 1'b1);
    rst_i = 1'b0;
    #1;
    chk("reset_drops_ack", ack_o, 1'b0);
    chk("reset_clears_dat", dat_o, 8'h00);
    stb_i = 1'b0; cyc_i = 1'b0;
    m_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    wb_rd(16'h100, "after_rst_status", g);
    chk("after_rst_status_zero", g, 8'h00);
    frame_rd(16'd5, "after_rst_frame5", g);
    chk("after_rst_frame5_zero", g, 8'h00);
    wb_rd(16'h0005, "after_rst_back5", g);
    chk("after_rst_back5_zero", g, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
